// File: rtl/riscv_pkg.sv
// Shared constants, slot types and decode helpers for the data-memory pipeline.
package riscv_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [2:0] LOAD_NONE = 3'b000;
   localparam logic [2:0] LOAD_LB   = 3'b001;
   localparam logic [2:0] LOAD_LH   = 3'b010;
   localparam logic [2:0] LOAD_LW   = 3'b011;
   localparam logic [2:0] LOAD_LBU  = 3'b100;
   localparam logic [2:0] LOAD_LHU  = 3'b101;

   localparam logic [1:0] STORE_NONE = 2'b00;
   localparam logic [1:0] STORE_SB   = 2'b01;
   localparam logic [1:0] STORE_SH   = 2'b10;
   localparam logic [1:0] STORE_SW   = 2'b11;

   // DM1 carries the store fields because requests only issue from DM1.
   typedef struct packed {
      logic [4:0]        rd;
      logic              we;
      logic [DATA_W-1:0] alu;
      logic [2:0]        load;
      logic [1:0]        store;
      logic [DATA_W-1:0] store_data;
      logic              wb_sel;
      logic [1:0]        offset;
   } dm1_slot_t;

   typedef struct packed {
      logic [4:0]        rd;
      logic              we;
      logic [DATA_W-1:0] alu;
      logic [2:0]        load;
      logic              wb_sel;
      logic [1:0]        offset;
   } dm_slot_t;

   // Codes 110/111 decode as no load.
   function automatic logic is_load(input logic [2:0] code);
      return (code != LOAD_NONE) && (code <= LOAD_LHU);
   endfunction

   function automatic logic is_mem_op(input logic [2:0] load, input logic [1:0] store);
      return is_load(load) || (store != STORE_NONE);
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational store strobe/data replication and load byte/half extract with extension.
module load_store_align
   import riscv_pkg::*;
(
   input  logic [1:0]        i_store_code,
   input  logic [1:0]        i_store_offset,
   input  logic [DATA_W-1:0] i_store_data,
   output logic [STRB_W-1:0] o_write_strobe,
   output logic [DATA_W-1:0] o_write_data,
   input  logic [2:0]        i_load_code,
   input  logic [1:0]        i_load_offset,
   input  logic [DATA_W-1:0] i_read_data,
   output logic [DATA_W-1:0] o_load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      o_write_strobe = '0;
      o_write_data   = i_store_data;
      case (i_store_code)
         STORE_SB: begin
            o_write_strobe = STRB_W'(1) << i_store_offset;
            o_write_data   = {4{i_store_data[7:0]}};
         end
         STORE_SH: begin
            o_write_strobe = i_store_offset[1] ? 4'b1100 : 4'b0011;
            o_write_data   = {2{i_store_data[15:0]}};
         end
         STORE_SW: o_write_strobe = 4'b1111;
         default:  ;
      endcase
   end

   always_comb begin
      w_byte = 8'h00;
      unique case (i_load_offset)
         2'd0: w_byte = i_read_data[7:0];
         2'd1: w_byte = i_read_data[15:8];
         2'd2: w_byte = i_read_data[23:16];
         2'd3: w_byte = i_read_data[31:24];
      endcase
      w_half = i_load_offset[1] ? i_read_data[31:16] : i_read_data[15:0];

      o_load_data = i_read_data;
      case (i_load_code)
         LOAD_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
         LOAD_LH:  o_load_data = {{16{w_half[15]}}, w_half};
         LOAD_LBU: o_load_data = {24'h000000, w_byte};
         LOAD_LHU: o_load_data = {16'h0000, w_half};
         default:  ;
      endcase
   end

endmodule

// File: rtl/data_memory_stage.sv
// DM1/DM2/DM3 data-memory pipeline with cache request issue, load alignment,
// forwarding taps and the write-back register.
module data_memory_stage
   import riscv_pkg::*;
#(
   parameter logic HIGH = 1'b1,
   parameter logic LOW  = 1'b0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              STALL_DATA_MEMORY_STAGE,
   input  logic [4:0]        RD_ADDRESS_IN,
   input  logic [DATA_W-1:0] ALU_OUT_IN,
   input  logic [2:0]        DATA_CACHE_LOAD_IN,
   input  logic [1:0]        DATA_CACHE_STORE_IN,
   input  logic [DATA_W-1:0] DATA_CACHE_STORE_DATA_IN,
   input  logic              WRITE_BACK_MUX_SELECT_IN,
   input  logic              RD_WRITE_ENABLE_IN,
   output logic              CACHE_REQ_VALID,
   input  logic              CACHE_REQ_READY,
   output logic [DATA_W-1:0] CACHE_REQ_ADDRESS,
   output logic [STRB_W-1:0] CACHE_REQ_WRITE_STROBE,
   output logic [DATA_W-1:0] CACHE_REQ_WRITE_DATA,
   input  logic              CACHE_RD_VALID,
   input  logic [DATA_W-1:0] CACHE_RD_DATA,
   output logic              STALL_REQUEST,
   output logic [DATA_W-1:0] RD_DATA_DM1,
   output logic [DATA_W-1:0] RD_DATA_DM2,
   output logic [DATA_W-1:0] RD_DATA_DM3,
   output logic [14:0]       FWD_RD_ADDRESS,
   output logic [2:0]        FWD_RD_WRITE_ENABLE,
   output logic [4:0]        RD_ADDRESS_OUT,
   output logic [DATA_W-1:0] RD_DATA_OUT,
   output logic              RD_WRITE_ENABLE_OUT
);

   dm1_slot_t         r_dm1;
   dm_slot_t          r_dm2;
   dm_slot_t          r_dm3;
   logic              r_issued;
   logic [4:0]        r_rd_address_out;
   logic [DATA_W-1:0] r_rd_data_out;
   logic              r_rd_write_enable_out;

   dm1_slot_t         w_ex_slot;
   logic              w_dm1_mem_op;
   logic              w_dm3_load;
   logic              w_handshake;
   logic              w_advance;
   logic [DATA_W-1:0] w_load_data;

   always_comb begin
      w_ex_slot            = '0;
      w_ex_slot.rd         = RD_ADDRESS_IN;
      w_ex_slot.we         = RD_WRITE_ENABLE_IN;
      w_ex_slot.alu        = ALU_OUT_IN;
      w_ex_slot.load       = DATA_CACHE_LOAD_IN;
      w_ex_slot.store      = DATA_CACHE_STORE_IN;
      w_ex_slot.store_data = DATA_CACHE_STORE_DATA_IN;
      w_ex_slot.wb_sel     = WRITE_BACK_MUX_SELECT_IN;
      w_ex_slot.offset     = ALU_OUT_IN[1:0];
   end

   load_store_align u_align (
      .i_store_code   (r_dm1.store),
      .i_store_offset (r_dm1.offset),
      .i_store_data   (r_dm1.store_data),
      .o_write_strobe (CACHE_REQ_WRITE_STROBE),
      .o_write_data   (CACHE_REQ_WRITE_DATA),
      .i_load_code    (r_dm3.load),
      .i_load_offset  (r_dm3.offset),
      .i_read_data    (CACHE_RD_DATA),
      .o_load_data    (w_load_data)
   );

   assign w_dm1_mem_op      = is_mem_op(r_dm1.load, r_dm1.store);
   assign w_dm3_load        = is_load(r_dm3.load) & r_dm3.wb_sel;
   assign CACHE_REQ_VALID   = w_dm1_mem_op & ~r_issued;
   assign CACHE_REQ_ADDRESS = {r_dm1.alu[DATA_W-1:2], 2'b00};
   assign w_handshake       = CACHE_REQ_VALID & CACHE_REQ_READY;

   assign STALL_REQUEST = (CACHE_REQ_VALID & ~CACHE_REQ_READY) | (w_dm3_load & ~CACHE_RD_VALID);
   assign w_advance     = ~STALL_REQUEST & ~STALL_DATA_MEMORY_STAGE;

   assign RD_DATA_DM1         = r_dm1.alu;
   assign RD_DATA_DM2         = r_dm2.alu;
   assign RD_DATA_DM3         = w_dm3_load ? w_load_data : r_dm3.alu;
   assign FWD_RD_ADDRESS      = {r_dm3.rd, r_dm2.rd, r_dm1.rd};
   assign FWD_RD_WRITE_ENABLE = {r_dm3.we, r_dm2.we, r_dm1.we};

   assign RD_ADDRESS_OUT      = r_rd_address_out;
   assign RD_DATA_OUT         = r_rd_data_out;
   assign RD_WRITE_ENABLE_OUT = r_rd_write_enable_out;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_dm1                 <= '0;
         r_dm2                 <= '0;
         r_dm3                 <= '0;
         r_issued              <= LOW;
         r_rd_address_out      <= '0;
         r_rd_data_out         <= '0;
         r_rd_write_enable_out <= LOW;
      end else if (w_advance) begin
         r_rd_address_out      <= r_dm3.rd;
         r_rd_data_out         <= RD_DATA_DM3;
         r_rd_write_enable_out <= r_dm3.we;
         r_dm3                 <= r_dm2;
         r_dm2                 <= '{rd: r_dm1.rd, we: r_dm1.we, alu: r_dm1.alu, load: r_dm1.load,
                                    wb_sel: r_dm1.wb_sel, offset: r_dm1.offset};
         r_dm1                 <= w_ex_slot;
         r_issued              <= LOW;
      end else if (w_handshake) begin
         // Request accepted while frozen: remember it so it is not re-issued.
         r_issued <= HIGH;
      end
   end

endmodule
